// File: rtl/mchan_synch_array.sv
// rtl/mchan_synch_array.sv - per-SID outstanding command tracker with completion event queue
//
// Purpose:
//   Tracks outstanding TCDM and EXT commands for NB_TRANS transaction IDs.
//   TX/RX command grants add cmd_nb to both of a slot's counters. The TCDM
//   and EXT engines release one command per pulse. A slot that drains to
//   zero raises a pending completion event. Pending events are presented
//   lowest SID first on a valid/ready port.
//
// Optional feature macro: MCHAN_SYNCH_ERR_EN
//   defined   : counters clamp to 0 or saturate to all-ones; underflow,
//               overflow and lost events set sticky err_o bits, which
//               err_clr_i clears.
//   undefined : counters wrap, err_o is tied to 0 and err_clr_i is ignored.
//
// Ports:
//   clk_i, rst_ni                        clock, async active-low reset
//   mchan_{tx,rx}_{req,gnt,sid,cmd_nb}_i command adds from the arbiters
//   {tcdm,ext}_{tx,rx}_synch_{req,sid}_i single-command releases
//   trans_status_o                       per-slot busy, with a one-cycle tail
//   term_valid_o/term_sid_o/term_ready_i completion event port
//   err_o / err_clr_i                    sticky per-slot error / clear
module mchan_synch_array #(
    parameter int NB_TRANS        = 4,
    parameter int TRANS_SID_WIDTH = 2,
    parameter int MCHAN_LEN_WIDTH = 6,
    parameter int CNT_WIDTH       = 10
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       mchan_tx_req_i,
    input  logic                       mchan_tx_gnt_i,
    input  logic [TRANS_SID_WIDTH-1:0] mchan_tx_sid_i,
    input  logic [MCHAN_LEN_WIDTH-1:0] mchan_tx_cmd_nb_i,
    input  logic                       mchan_rx_req_i,
    input  logic                       mchan_rx_gnt_i,
    input  logic [TRANS_SID_WIDTH-1:0] mchan_rx_sid_i,
    input  logic [MCHAN_LEN_WIDTH-1:0] mchan_rx_cmd_nb_i,
    input  logic                       tcdm_tx_synch_req_i,
    input  logic [TRANS_SID_WIDTH-1:0] tcdm_tx_synch_sid_i,
    input  logic                       tcdm_rx_synch_req_i,
    input  logic [TRANS_SID_WIDTH-1:0] tcdm_rx_synch_sid_i,
    input  logic                       ext_tx_synch_req_i,
    input  logic [TRANS_SID_WIDTH-1:0] ext_tx_synch_sid_i,
    input  logic                       ext_rx_synch_req_i,
    input  logic [TRANS_SID_WIDTH-1:0] ext_rx_synch_sid_i,
    output logic [NB_TRANS-1:0]        trans_status_o,
    output logic                       term_valid_o,
    output logic [TRANS_SID_WIDTH-1:0] term_sid_o,
    input  logic                       term_ready_i,
    output logic [NB_TRANS-1:0]        err_o,
    input  logic [NB_TRANS-1:0]        err_clr_i
);

    // Two extra bits hold the sign and the carry of the per-cycle sum.
    localparam int SW = CNT_WIDTH + 2;

    logic [NB_TRANS-1:0]        busy;
    logic [NB_TRANS-1:0]        busy_reg_q;
    logic [NB_TRANS-1:0]        set_evt;
    logic [NB_TRANS-1:0]        pop_mask;
    logic [NB_TRANS-1:0]        pending_d, pending_q;
    logic [NB_TRANS-1:0]        slot_err;
    logic [TRANS_SID_WIDTH-1:0] term_sid;
    logic                       found;

    for (genvar s = 0; s < NB_TRANS; s++) begin : g_slot
        localparam logic [TRANS_SID_WIDTH-1:0] SID = TRANS_SID_WIDTH'(s);

        logic                 add_tx, add_rx;
        logic                 rel_tt, rel_tr, rel_et, rel_er;
        logic [SW-1:0]        tx_nb, rx_nb;
        logic [SW-1:0]        tcdm_sum, ext_sum;
        logic [CNT_WIDTH-1:0] tcdm_cnt_d, tcdm_cnt_q;
        logic [CNT_WIDTH-1:0] ext_cnt_d, ext_cnt_q;

        // Slot indices never reach NB_TRANS, so out-of-range SIDs match nothing.
        assign add_tx = mchan_tx_req_i & mchan_tx_gnt_i & (mchan_tx_sid_i == SID);
        assign add_rx = mchan_rx_req_i & mchan_rx_gnt_i & (mchan_rx_sid_i == SID);
        assign rel_tt = tcdm_tx_synch_req_i & (tcdm_tx_synch_sid_i == SID);
        assign rel_tr = tcdm_rx_synch_req_i & (tcdm_rx_synch_sid_i == SID);
        assign rel_et = ext_tx_synch_req_i  & (ext_tx_synch_sid_i  == SID);
        assign rel_er = ext_rx_synch_req_i  & (ext_rx_synch_sid_i  == SID);

        assign tx_nb = add_tx ? SW'(mchan_tx_cmd_nb_i) : '0;
        assign rx_nb = add_rx ? SW'(mchan_rx_cmd_nb_i) : '0;

        // Two's complement sum: bit SW-1 set means the result went below zero.
        assign tcdm_sum = SW'(tcdm_cnt_q) + tx_nb + rx_nb - SW'(rel_tt) - SW'(rel_tr);
        assign ext_sum  = SW'(ext_cnt_q)  + tx_nb + rx_nb - SW'(rel_et) - SW'(rel_er);

`ifdef MCHAN_SYNCH_ERR_EN
        logic tcdm_neg, tcdm_ovf, ext_neg, ext_ovf;

        assign tcdm_neg = tcdm_sum[SW-1];
        assign ext_neg  = ext_sum[SW-1];
        assign tcdm_ovf = ~tcdm_sum[SW-1] & tcdm_sum[SW-2];
        assign ext_ovf  = ~ext_sum[SW-1]  & (|ext_sum[SW-2:CNT_WIDTH]);

        assign tcdm_cnt_d = tcdm_neg ? '0 : (tcdm_ovf | tcdm_sum[CNT_WIDTH]) ? '1
                                          : tcdm_sum[CNT_WIDTH-1:0];
        assign ext_cnt_d  = ext_neg  ? '0 : ext_ovf ? '1 : ext_sum[CNT_WIDTH-1:0];

        // A completion landing on a still-pending, un-popped slot is lost.
        assign slot_err[s] = tcdm_neg | tcdm_ovf | tcdm_sum[CNT_WIDTH] & ~tcdm_neg
                           | ext_neg | ext_ovf
                           | (set_evt[s] & pending_q[s] & ~pop_mask[s]);
`else
        logic unused_sum_hi;

        assign tcdm_cnt_d    = tcdm_sum[CNT_WIDTH-1:0];
        assign ext_cnt_d     = ext_sum[CNT_WIDTH-1:0];
        assign unused_sum_hi = ^{tcdm_sum[SW-1:CNT_WIDTH], ext_sum[SW-1:CNT_WIDTH]};
        assign slot_err[s]   = 1'b0;
`endif

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                tcdm_cnt_q <= '0;
                ext_cnt_q  <= '0;
            end else begin
                tcdm_cnt_q <= tcdm_cnt_d;
                ext_cnt_q  <= ext_cnt_d;
            end
        end

        assign busy[s] = (|tcdm_cnt_q) | (|ext_cnt_q);
    end

    // Falling edge of the registered busy marks a completion.
    assign set_evt = busy_reg_q & ~busy;

    // Fixed priority: lowest pending SID is presented and popped.
    always_comb begin
        term_sid = '0;
        pop_mask = '0;
        found    = 1'b0;
        for (int i = 0; i < NB_TRANS; i++) begin
            if (pending_q[i] && !found) begin
                found       = 1'b1;
                term_sid    = TRANS_SID_WIDTH'(i);
                pop_mask[i] = term_ready_i;
            end
        end
    end

    // Set dominates a same-cycle pop of the same slot.
    assign pending_d = set_evt | (pending_q & ~pop_mask);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_reg_q <= '0;
            pending_q  <= '0;
        end else begin
            busy_reg_q <= busy;
            pending_q  <= pending_d;
        end
    end

`ifdef MCHAN_SYNCH_ERR_EN
    logic [NB_TRANS-1:0] err_q;

    // A new error dominates a same-cycle clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= '0;
        end else begin
            err_q <= slot_err | (err_q & ~err_clr_i);
        end
    end

    assign err_o = err_q;
`else
    logic unused_err;

    assign unused_err = ^{err_clr_i, slot_err};
    assign err_o      = '0;
`endif

    assign trans_status_o = busy | busy_reg_q;
    assign term_valid_o   = |pending_q;
    assign term_sid_o     = term_sid;

endmodule
